ocx_tlx_framer_rsp_fifo_param: RTL and testbench

OCX_TLX_FRAMER_RSP_FIFO_PARAM -- requirements
Module: ocx_tlx_framer_rsp_fifo_param

---
 rtl/ocx_tlx_framer_rsp_fifo_param.sv | 95 +++++++++
 tb/tb_ocx_tlx_framer_rsp_fifo_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ocx_tlx_framer_rsp_fifo_param.sv
// Response FIFO for the TLX framer: first-word fall-through, sticky error status.
// Optional peak-occupancy tracking is enabled with OCX_TLX_RSP_FIFO_HWM_EN.
module ocx_tlx_framer_rsp_fifo_param #(
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int REGFILE_DEPTH   = 2**FIFO_ADDR_WIDTH,
  parameter int REGFILE_WIDTH   = 59,
  parameter int AFULL_THRESH    = REGFILE_DEPTH-2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REGFILE_WIDTH-1:0] data_in,
  input  logic                     wr_enable,
  input  logic                     rd_done,
  input  logic                     err_clear,
  output logic [REGFILE_WIDTH-1:0] data_out,
  output logic                     data_available,
  output logic                     full,
  output logic                     almost_full,
  output logic [FIFO_ADDR_WIDTH:0] valid_entry_count,
  output logic                     underflow_error,
  output logic                     overflow_error,
  output logic [1:0]               err_status
`ifdef OCX_TLX_RSP_FIFO_HWM_EN
  ,
  input  logic                     hwm_clear,
  output logic [FIFO_ADDR_WIDTH:0] high_water_mark
`endif
);

  localparam int CW = FIFO_ADDR_WIDTH + 1;

  logic [REGFILE_WIDTH-1:0]   regfile [REGFILE_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]              count;
  logic [CW-1:0]              count_next;
  logic                       acc_wr;
  logic                       acc_rd;

  assign data_available    = count != '0;
  assign full              = count == CW'(REGFILE_DEPTH);
  assign almost_full       = count >= CW'(AFULL_THRESH);
  assign valid_entry_count = count;
  assign data_out          = regfile[rd_ptr];

  // A full FIFO still takes a write when the head is consumed in the same cycle.
  assign acc_wr = wr_enable && (!full || rd_done);
  assign acc_rd = rd_done && data_available;

  assign underflow_error = rd_done && !data_available;
  assign overflow_error  = wr_enable && full && !rd_done;

  always_comb begin
    count_next = count;
    if (acc_wr && !acc_rd)
      count_next = count + CW'(1);
    else if (acc_rd && !acc_wr)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset && acc_wr)
      regfile[wr_ptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_status <= 2'b00;
    end else begin
      if (acc_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (acc_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // A fresh error in the clearing cycle stays visible.
      err_status <= (err_clear ? 2'b00 : err_status)
                  | {overflow_error, underflow_error};
    end
  end

`ifdef OCX_TLX_RSP_FIFO_HWM_EN
  always_ff @(posedge clock) begin
    if (reset)
      high_water_mark <= '0;
    else if (hwm_clear)
      high_water_mark <= count_next;
    else if (count_next > high_water_mark)
      high_water_mark <= count_next;
  end
`endif

endmodule

// File: tb/tb_ocx_tlx_framer_rsp_fifo_param.sv
// Bench for ocx_tlx_framer_rsp_fifo_param: vector table, corner sequences,
// and random traffic against a queue model.
module tb_ocx_tlx_framer_rsp_fifo_param;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int W     = 59;
  localparam int AF    = DEPTH - 2;

  logic          clock;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          wr_enable;
  logic          rd_done;
  logic          err_clear;
  logic [W-1:0]  data_out;
  logic          data_available;
  logic          full;
  logic          almost_full;
  logic [AW:0]   valid_entry_count;
  logic          underflow_error;
  logic          overflow_error;
  logic [1:0]    err_status;
  logic          hwm_clear;
`ifdef OCX_TLX_RSP_FIFO_HWM_EN
  logic [AW:0]   high_water_mark;
`endif

  ocx_tlx_framer_rsp_fifo_param dut (
    .clock             (clock),
    .reset             (reset),
    .data_in           (data_in),
    .wr_enable         (wr_enable),
    .rd_done           (rd_done),
    .err_clear         (err_clear),
    .data_out          (data_out),
    .data_available    (data_available),
    .full              (full),
    .almost_full       (almost_full),
    .valid_entry_count (valid_entry_count),
    .underflow_error   (underflow_error),
    .overflow_error    (overflow_error),
    .err_status        (err_status)
`ifdef OCX_TLX_RSP_FIFO_HWM_EN
    ,
    .hwm_clear         (hwm_clear),
    .high_water_mark   (high_water_mark)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int failures;

  logic [W-1:0] q[$];
  logic [1:0]   m_err;
  int           m_hwm;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit wr, bit rd, bit clr, bit hclr,
                       logic [W-1:0] d);
    @(negedge clock);
    reset     = rst;
    wr_enable = wr;
    rd_done   = rd;
    err_clear = clr;
    hwm_clear = hclr;
    data_in   = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One model-checked cycle: outputs are compared before the edge
  // against the model state, then the model advances.
  task automatic cycle(bit rst, bit wr, bit rd, bit clr, bit hclr,
                       logic [W-1:0] d);
    int  cnt;
    bit  unf;
    bit  ovf;
    bit  aw;
    bit  ar;
    drive(rst, wr, rd, clr, hclr, d);
    cnt = q.size();
    unf = rd && cnt == 0;
    ovf = wr && cnt == DEPTH && !rd;
    chk("count", 64'(valid_entry_count), 64'(cnt));
    chk("data_available", 64'(data_available), 64'(cnt > 0));
    chk("full", 64'(full), 64'(cnt == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(cnt >= AF));
    chk("underflow_error", 64'(underflow_error), 64'(unf));
    chk("overflow_error", 64'(overflow_error), 64'(ovf));
    chk("err_status", 64'(err_status), 64'(m_err));
    if (cnt > 0)
      chk("data_out", 64'(data_out), 64'(q[0]));
`ifdef OCX_TLX_RSP_FIFO_HWM_EN
    chk("high_water_mark", 64'(high_water_mark), 64'(m_hwm));
`endif
    if (rst) begin
      q.delete();
      m_err = 2'b00;
      m_hwm = 0;
    end else begin
      ar = rd && cnt > 0;
      aw = wr && (cnt < DEPTH || rd);
      if (ar)
        void'(q.pop_front());
      if (aw)
        q.push_back(d);
      m_err = (clr ? 2'b00 : m_err) | {ovf, unf};
      if (hclr)
        m_hwm = q.size();
      else if (q.size() > m_hwm)
        m_hwm = q.size();
    end
    tick();
  endtask

  typedef struct {
    bit           rst;
    bit           wr;
    bit           rd;
    bit           clr;
    logic [W-1:0] d;
    bit           e_unf;
    bit           e_ovf;
    bit           chk_dout;
    logic [W-1:0] e_dout;
    int           e_cnt;
    logic [1:0]   e_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    wr_enable = 1'b0;
    rd_done   = 1'b0;
    err_clear = 1'b0;
    hwm_clear = 1'b0;
    data_in   = '0;
    m_err     = 2'b00;
    m_hwm     = 0;

    //          rst wr rd clr d      unf ovf cd dout  cnt err
    tbl[0] = '{1, 0, 0, 0, 59'h00, 0, 0, 0, 59'h00, 0, 2'b00};
    tbl[1] = '{0, 0, 1, 0, 59'h00, 1, 0, 0, 59'h00, 0, 2'b01};
    tbl[2] = '{0, 0, 0, 1, 59'h00, 0, 0, 0, 59'h00, 0, 2'b00};
    tbl[3] = '{0, 1, 0, 0, 59'h11, 0, 0, 0, 59'h00, 1, 2'b00};
    tbl[4] = '{0, 1, 1, 0, 59'h22, 0, 0, 1, 59'h11, 1, 2'b00};
    tbl[5] = '{0, 0, 1, 0, 59'h00, 0, 0, 1, 59'h22, 0, 2'b00};
    tbl[6] = '{0, 1, 1, 0, 59'h33, 1, 0, 0, 59'h00, 1, 2'b01};
    tbl[7] = '{0, 0, 1, 1, 59'h00, 0, 0, 1, 59'h33, 0, 2'b00};
    tbl[8] = '{0, 0, 1, 1, 59'h00, 1, 0, 0, 59'h00, 0, 2'b01};
    tbl[9] = '{1, 0, 0, 0, 59'h00, 0, 0, 0, 59'h00, 0, 2'b00};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].clr, 1'b0, tbl[i].d);
      chk($sformatf("vec%0d.underflow", i), 64'(underflow_error),
          64'(tbl[i].e_unf));
      chk($sformatf("vec%0d.overflow", i), 64'(overflow_error),
          64'(tbl[i].e_ovf));
      if (tbl[i].chk_dout)
        chk($sformatf("vec%0d.data_out", i), 64'(data_out),
            64'(tbl[i].e_dout));
      tick();
      chk($sformatf("vec%0d.count", i), 64'(valid_entry_count),
          64'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.err_status", i), 64'(err_status),
          64'(tbl[i].e_err));
    end

    // Fill to full with 0x01..0x08.
    cycle(1, 0, 0, 0, 0, '0);
    for (int i = 1; i <= DEPTH; i++)
      cycle(0, 1, 0, 0, 0, W'(i));
    drive(0, 0, 0, 0, 0, '0);
    chk("fill.full", 64'(full), 64'(1));
    chk("fill.count", 64'(valid_entry_count), 64'(8));
    chk("fill.data_out", 64'(data_out), 64'(1));
    tick();

    // Overflow: 0xAA must be dropped.
    cycle(0, 1, 0, 0, 0, W'(8'hAA));
    drive(0, 0, 0, 0, 0, '0);
    chk("ovf.err_status", 64'(err_status), 64'(2'b10));
    chk("ovf.count", 64'(valid_entry_count), 64'(8));
    tick();

    // Full with simultaneous read/write for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 0, 0, W'(8'h40 + i));
      chk("wrap.count", 64'(valid_entry_count), 64'(8));
    end
    for (int i = 0; i < DEPTH; i++)
      cycle(0, 0, 1, 1, 0, '0);

    // Empty with rd+wr: write lands, read flagged.
    cycle(0, 1, 1, 0, 0, W'(8'h55));
    drive(0, 0, 0, 0, 0, '0);
    chk("unf.count", 64'(valid_entry_count), 64'(1));
    chk("unf.data_out", 64'(data_out), 64'(8'h55));
    chk("unf.err_status", 64'(err_status), 64'(2'b01));
    tick();

    // Reset mid-operation at count 5 with a write pending.
    cycle(0, 0, 0, 1, 0, '0);
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 0, 0, 0, W'(i + 2));
    cycle(0, 0, 0, 0, 0, '0);
    cycle(1, 1, 0, 0, 0, W'(8'h77));
    drive(0, 0, 0, 0, 0, '0);
    chk("rst.count", 64'(valid_entry_count), 64'(0));
    chk("rst.data_available", 64'(data_available), 64'(0));
    chk("rst.err_status", 64'(err_status), 64'(0));
    tick();
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 0, 0, 0, W'(i + 9));
    cycle(0, 0, 0, 0, 1, '0);
    cycle(0, 0, 0, 0, 0, '0);

    // Random traffic: write-heavy then read-heavy phases.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        bit rst;
        bit wr;
        bit rd;
        bit clr;
        bit hclr;
        rst  = $urandom_range(0, 199) == 0;
        wr   = $urandom_range(0, 99) < (ph == 0 ? 65 : 35);
        rd   = $urandom_range(0, 99) < (ph == 0 ? 40 : 65);
        clr  = $urandom_range(0, 19) == 0;
        hclr = $urandom_range(0, 29) == 0;
        cycle(rst, wr, rd, clr, hclr, {$urandom, $urandom});
      end
    end
    cycle(0, 0, 0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
